// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory access controller.
//   state_t    - controller FSM states
//   PORT_IF/D  - request port identifiers (instruction fetch / load-store)
//   DEF_*_W    - default RAM address and data widths
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arb.sv
// mem_arb: combinational fixed-priority grant between the fetch and data ports.
//   enable        in   controller can take a request this cycle
//   if_req_valid  in   fetch request
//   d_req_valid   in   load/store request
//   if_req_ready  out  fetch accepted
//   d_req_ready   out  data accepted
//   grant_port    out  port that wins when a request is taken
module mem_arb
    import mem_ctrl_pkg::*;
(
    input  logic enable,
    input  logic if_req_valid,
    input  logic d_req_valid,
    output logic if_req_ready,
    output logic d_req_ready,
    output logic grant_port
);

    // Data port always wins; a waiting fetch has no starvation protection.
    always_comb begin
        d_req_ready  = enable & d_req_valid;
        if_req_ready = enable & if_req_valid & ~d_req_valid;
        grant_port   = d_req_valid ? PORT_D : PORT_IF;
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences one single-port RAM access at a time for the fetch and
// load/store ports and returns registered responses.
//   clk, reset_n             clock, synchronous active-low reset
//   if_req_*, if_addr        fetch request handshake and address
//   if_rsp_valid/data        fetch response pulse and word
//   d_req_*, d_addr, d_wdata load/store request handshake, address, store data
//   d_rsp_valid/data         load data or store ack pulse, load word
//   ram_*                    RAM address, write data, enables, read data
//
// state  | meaning
// IDLE   | ready for a new request
// ACCESS | RAM enable asserted for the latched request
// WAIT   | read data returning from RAM, captured this cycle
// RESP   | response pulse to the owning port
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_out
);

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_we;
    logic              req_port;

    logic              arb_enable;
    logic              grant_port;
    logic              accept;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    logic              read_en_next;
    logic              write_en_next;
    logic              if_rsp_next;
    logic              d_rsp_next;
    logic              capture;

    // Ready is held low while reset is asserted, even though the state is IDLE.
    assign arb_enable = reset_n & (state == IDLE);

    mem_arb u_arb (
        .enable       (arb_enable),
        .if_req_valid (if_req_valid),
        .d_req_valid  (d_req_valid),
        .if_req_ready (if_req_ready),
        .d_req_ready  (d_req_ready),
        .grant_port   (grant_port)
    );

    // Each ready already includes its valid.
    assign accept = if_req_ready | d_req_ready;

    always_comb begin
        sel_addr  = if_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (grant_port == PORT_D) begin
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
            sel_we    = d_req_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = req_we ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs, so enables and response pulses
    // come straight from flops.
    always_comb begin
        read_en_next  = 1'b0;
        write_en_next = 1'b0;
        if_rsp_next   = 1'b0;
        d_rsp_next    = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                read_en_next  = accept & ~sel_we;
                write_en_next = accept & sel_we;
            end
            ACCESS: begin
                if_rsp_next = req_we & (req_port == PORT_IF);
                d_rsp_next  = req_we & (req_port == PORT_D);
            end
            WAIT: begin
                capture     = 1'b1;
                if_rsp_next = (req_port == PORT_IF);
                d_rsp_next  = (req_port == PORT_D);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_addr         <= '0;
            req_wdata        <= '0;
            req_we           <= 1'b0;
            req_port         <= PORT_IF;
            ram_read_enable  <= 1'b0;
            ram_write_enable <= 1'b0;
            if_rsp_valid     <= 1'b0;
            d_rsp_valid      <= 1'b0;
            if_rsp_data      <= '0;
            d_rsp_data       <= '0;
        end else begin
            ram_read_enable  <= read_en_next;
            ram_write_enable <= write_en_next;
            if_rsp_valid     <= if_rsp_next;
            d_rsp_valid      <= d_rsp_next;
            if (accept) begin
                req_addr  <= sel_addr;
                req_wdata <= sel_wdata;
                req_we    <= sel_we;
                req_port  <= grant_port;
            end
            if (capture) begin
                if (req_port == PORT_IF) begin
                    if_rsp_data <= ram_data_out;
                end else begin
                    d_rsp_data <= ram_data_out;
                end
            end
        end
    end

    assign ram_address = req_addr;
    assign ram_data_in = req_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req_valid = 1'b0;
    logic          if_req_ready;
    logic [AW-1:0] if_addr = '0;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          d_req_valid = 1'b0;
    logic          d_req_ready;
    logic          d_req_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_write_enable;
    logic          ram_read_enable;
    logic [DW-1:0] ram_data_out = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_req_valid     (if_req_valid),
        .if_req_ready     (if_req_ready),
        .if_addr          (if_addr),
        .if_rsp_valid     (if_rsp_valid),
        .if_rsp_data      (if_rsp_data),
        .d_req_valid      (d_req_valid),
        .d_req_ready      (d_req_ready),
        .d_req_we         (d_req_we),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_rsp_valid      (d_rsp_valid),
        .d_rsp_data       (d_rsp_data),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_data_out     (ram_data_out)
    );

    // Single-port RAM with registered read; pre_* loads contents while idle.
    logic [DW-1:0] ram [256];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (ram_write_enable) ram[ram_address] <= ram_data_in;
        if (ram_read_enable) ram_data_out <= ram[ram_address];
    end

    // Reference memory contents as the bench expects them.
    logic [DW-1:0] ref_mem [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        if_addr      = 8'($urandom);
        d_addr       = 8'($urandom);
        d_req_we     = 1'b1;
        d_wdata      = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                 ram_write_enable, ram_read_enable} !== 6'b0 ||
                if_rsp_data !== '0 || d_rsp_data !== '0 ||
                ram_address !== '0 || ram_data_in !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: rdy if/d %b/%b rsp_v if/d %b/%b en w/r %b/%b addr %h din %h rsp if/d %h/%h, required all 0",
                         i, if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                         ram_write_enable, ram_read_enable, ram_address, ram_data_in,
                         if_rsp_data, d_rsp_data);
            end
        end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: d/if ready %b/%b, required 1/0", d_req_ready, if_req_ready);
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        tick();
    endtask

    task automatic test_fetch_read();
        preload(8'h00, 32'h02000054);
        if_req_valid = 1'b1;
        if_addr      = 8'h00;
        @(negedge clk);
        checks++;
        if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ready: if/d ready %b/%b, required 1/0", if_req_ready, d_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_read_enable !== 1'b1 || ram_write_enable !== 1'b0 || ram_address !== 8'h00) begin
            errors++;
            $display("FAIL fetch_ram_en: re %b we %b addr %h, required 1 0 00", ram_read_enable, ram_write_enable, ram_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ram_read_enable !== 1'b0 || if_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_t2: re %b rsp_valid %b, required 0 0", ram_read_enable, if_rsp_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h02000054 || d_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp: valid %b data %h d_valid %b, required 1 02000054 0", if_rsp_valid, if_rsp_data, d_rsp_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp_pulse: valid %b, required 0", if_rsp_valid);
        end
    endtask

    task automatic test_store_load();
        tick();
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_addr      = 8'h52;
        d_wdata     = 32'h0000002F;
        ref_mem[8'h52] = 32'h0000002F;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_ready: %b, required 1", d_req_ready);
        end
        tick();
        d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_write_enable !== 1'b1 || ram_read_enable !== 1'b0 ||
            ram_address !== 8'h52 || ram_data_in !== 32'h0000002F) begin
            errors++;
            $display("FAIL store_ram: we %b re %b addr %h din %h, required 1 0 52 0000002f",
                     ram_write_enable, ram_read_enable, ram_address, ram_data_in);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ram_write_enable !== 1'b0 || d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL store_ack: we %b ack %b data %h, required 0 1 00000000", ram_write_enable, d_rsp_valid, d_rsp_data);
        end
        tick();
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1 || d_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_accept: ready %b ack %b, required 1 0", d_req_ready, d_rsp_valid);
        end
        tick();
        d_req_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (d_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_early: valid %b, required 0", d_rsp_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0000002F) begin
            errors++;
            $display("FAIL load_rsp: valid %b data %h, required 1 0000002f", d_rsp_valid, d_rsp_data);
        end
        tick();
    endtask

    task automatic test_collision();
        logic [DW-1:0] fw;
        fw = $urandom;
        preload(8'h68, 32'h00000055);
        preload(8'h0A, fw);
        if_req_valid = 1'b1;
        if_addr      = 8'h0A;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        d_addr       = 8'h68;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_prio: d/if ready %b/%b, required 1/0", d_req_ready, if_req_ready);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            d_req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (if_req_ready !== 1'b0 || d_rsp_valid !== (i == 3)) begin
                errors++;
                $display("FAIL coll_busy t%0d: if_ready %b d_rsp_valid %b, required 0 %b", i, if_req_ready, d_rsp_valid, (i == 3));
            end
        end
        checks++;
        if (d_rsp_data !== 32'h00000055) begin
            errors++;
            $display("FAIL coll_load_data: %h, required 00000055", d_rsp_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_fetch_accept: if_ready %b, required 1", if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== fw) begin
            errors++;
            $display("FAIL coll_fetch_rsp: valid %b data %h, required 1 %h", if_rsp_valid, if_rsp_data, fw);
        end
        tick();
    endtask

    task automatic test_streaming();
        int            rsp_cyc [$];
        logic [DW-1:0] rsp_dat [$];
        int            acc_n;
        logic          took;
        acc_n = 0;
        for (int a = 0; a < 3; a++) preload(8'(a), $urandom);
        if_req_valid = 1'b1;
        if_addr      = 8'h00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if_rsp_valid === 1'b1) begin
                rsp_cyc.push_back(c);
                rsp_dat.push_back(if_rsp_data);
            end
            took = (if_req_ready === 1'b1) && if_req_valid;
            tick();
            if (took) begin
                acc_n++;
                if (acc_n < 3) if_addr = 8'(acc_n);
                else if_req_valid = 1'b0;
            end
        end
        if_req_valid = 1'b0;
        checks++;
        if (rsp_cyc.size() != 3) begin
            errors++;
            $display("FAIL stream_count: %0d responses, required 3", rsp_cyc.size());
        end
        for (int i = 0; i < 3 && i < rsp_cyc.size(); i++) begin
            checks++;
            if (rsp_cyc[i] != 3 + 4 * i || rsp_dat[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL stream_rsp%0d: cycle %0d data %h, required cycle %0d data %h",
                         i, rsp_cyc[i], rsp_dat[i], 3 + 4 * i, ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_wait();
        logic [DW-1:0] w;
        w = $urandom;
        preload(8'h33, w);
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_addr      = 8'h33;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstw_accept: ready %b, required 1", d_req_ready);
        end
        tick();
        d_req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        tick();
        reset_n     = 1'b1;
        d_req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (d_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0 || ram_read_enable !== 1'b0 ||
            ram_write_enable !== 1'b0 || d_req_ready !== 1'b1 || d_rsp_data !== '0) begin
            errors++;
            $display("FAIL rstw_after: rsp_v d/if %b/%b en r/w %b/%b ready %b data %h, required 0/0 0/0 1 00000000",
                     d_rsp_valid, if_rsp_valid, ram_read_enable, ram_write_enable, d_req_ready, d_rsp_data);
        end
        tick();
        d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_read_enable !== 1'b1 || ram_address !== 8'h33) begin
            errors++;
            $display("FAIL rstw_reissue_en: re %b addr %h, required 1 33", ram_read_enable, ram_address);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== w) begin
            errors++;
            $display("FAIL rstw_reissue_rsp: valid %b data %h, required 1 %h", d_rsp_valid, d_rsp_data, w);
        end
        tick();
    endtask

    // Randomized traffic against a transaction-level model: each accepted
    // request owns the RAM for 4 cycles (read) or 3 (write), and its response
    // lands 3 or 2 cycles after accept.
    task automatic test_random();
        int            next_free, p_rsp, p_acc;
        logic          p_we, p_port;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data, p_wdata, last_if, last_d;
        logic          m_if_rdy, m_d_rdy;
        next_free = 0; p_rsp = -1; p_acc = -10;
        p_we = 1'b0; p_port = 1'b0; p_addr = '0;
        p_data = '0; p_wdata = '0; last_if = '0; last_d = '0;

        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        reset_n      = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) preload(8'(a), $urandom);

        for (int c = 0; c < 400; c++) begin
            m_d_rdy  = (c >= next_free) && d_req_valid;
            m_if_rdy = (c >= next_free) && if_req_valid && !d_req_valid;
            if (c == p_rsp && !p_we) begin
                if (p_port) last_d = p_data;
                else last_if = p_data;
            end
            @(negedge clk);
            checks++;
            if (if_req_ready !== m_if_rdy || d_req_ready !== m_d_rdy) begin
                errors++;
                $display("FAIL rnd_ready c%0d: if/d %b/%b, required %b/%b", c, if_req_ready, d_req_ready, m_if_rdy, m_d_rdy);
            end
            checks++;
            if (if_rsp_valid !== (c == p_rsp && !p_port) || d_rsp_valid !== (c == p_rsp && p_port)) begin
                errors++;
                $display("FAIL rnd_rsp_valid c%0d: if/d %b/%b, required %b/%b", c, if_rsp_valid, d_rsp_valid,
                         (c == p_rsp && !p_port), (c == p_rsp && p_port));
            end
            checks++;
            if (if_rsp_data !== last_if || d_rsp_data !== last_d) begin
                errors++;
                $display("FAIL rnd_rsp_data c%0d: if/d %h/%h, required %h/%h", c, if_rsp_data, d_rsp_data, last_if, last_d);
            end
            checks++;
            if (ram_read_enable !== (c == p_acc + 1 && !p_we) || ram_write_enable !== (c == p_acc + 1 && p_we)) begin
                errors++;
                $display("FAIL rnd_enables c%0d: re/we %b/%b, required %b/%b", c, ram_read_enable, ram_write_enable,
                         (c == p_acc + 1 && !p_we), (c == p_acc + 1 && p_we));
            end
            if (c == p_acc + 1) begin
                checks++;
                if (ram_address !== p_addr || (p_we && ram_data_in !== p_wdata)) begin
                    errors++;
                    $display("FAIL rnd_ram_bus c%0d: addr %h din %h, required addr %h din %h", c, ram_address, ram_data_in, p_addr, p_wdata);
                end
            end
            if (m_d_rdy) begin
                p_acc = c; p_we = d_req_we; p_port = 1'b1; p_addr = d_addr; p_wdata = d_wdata;
                if (d_req_we) begin
                    ref_mem[d_addr] = d_wdata;
                    p_rsp = c + 2;
                    next_free = c + 3;
                end else begin
                    p_data = ref_mem[d_addr];
                    p_rsp = c + 3;
                    next_free = c + 4;
                end
            end else if (m_if_rdy) begin
                p_acc = c; p_we = 1'b0; p_port = 1'b0; p_addr = if_addr;
                p_data = ref_mem[if_addr];
                p_rsp = c + 3;
                next_free = c + 4;
            end
            tick();
            if (d_req_valid && (m_d_rdy || $urandom_range(15) == 0)) d_req_valid = 1'b0;
            if (!d_req_valid && $urandom_range(3) == 0) begin
                d_req_valid = 1'b1;
                d_req_we    = 1'($urandom_range(1));
                d_addr      = 8'($urandom_range(15));
                d_wdata     = $urandom;
            end
            if (if_req_valid && (m_if_rdy || $urandom_range(15) == 0)) if_req_valid = 1'b0;
            if (!if_req_valid && $urandom_range(1) == 0) begin
                if_req_valid = 1'b1;
                if_addr      = 8'($urandom_range(15));
            end
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_store_load();
        test_collision();
        test_streaming();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
